// File: rtl/caddr_seq_pkg.sv
// Shared encodings for the code-address sequencer: FSM states, opcodes,
// caddr command values and the instruction class produced by the decoder.
package bxu_seq_pkg;

  localparam logic [1:0] CADDR_NOP = 2'h0;
  localparam logic [1:0] CADDR_INC = 2'h1;
  localparam logic [1:0] CADDR_MOD = 2'h2;
  localparam logic [1:0] CADDR_SET = 2'h3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMPR = 4'h1;
  localparam logic [3:0] OP_JMPA = 4'h2;
  localparam logic [3:0] OP_BRZ  = 4'h3;
  localparam logic [3:0] OP_BRNZ = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;

  typedef enum logic [1:0] {
    CLS_CTRL = 2'd0,
    CLS_EXEC = 2'd1,
    CLS_HALT = 2'd2
  } instr_class_e;

endpackage

// File: rtl/caddr_seq_if.sv
// Code-memory fetch port and execute-unit handshake of the sequencer.
// The sequencer is the master; memory and execute unit sit on the slave side.
interface caddr_seq_if #(
  parameter int ADDR_BITWIDTH = 16,
  parameter int CODE_BITWIDTH = 16
);
  logic                     code_req;
  logic [ADDR_BITWIDTH-1:0] fetch_addr;
  logic                     code_ack;
  logic [CODE_BITWIDTH-1:0] code_rdata;
  logic                     ex_valid;
  logic                     ex_ready;

  modport master (
    output code_req, fetch_addr, ex_valid,
    input  code_ack, code_rdata, ex_ready
  );

  modport slave (
    input  code_req, fetch_addr, ex_valid,
    output code_ack, code_rdata, ex_ready
  );
endinterface

// File: rtl/caddr_seq_dec.sv
// Combinational opcode decoder: instruction class plus the command the
// code-address unit receives once the instruction completes.
module seq_op_dec
  import bxu_seq_pkg::*;
(
  input  logic [3:0]   opcode,
  input  logic         cond_z,
  output instr_class_e instr_class,
  output logic [1:0]   caddr_cmd
);

  always_comb begin
    instr_class = CLS_EXEC;
    caddr_cmd   = CADDR_INC;
    case (opcode)
      OP_NOP: begin
        instr_class = CLS_CTRL;
        caddr_cmd   = CADDR_INC;
      end
      OP_JMPR: begin
        instr_class = CLS_CTRL;
        caddr_cmd   = CADDR_MOD;
      end
      OP_JMPA: begin
        instr_class = CLS_CTRL;
        caddr_cmd   = CADDR_SET;
      end
      OP_BRZ: begin
        instr_class = CLS_CTRL;
        caddr_cmd   = cond_z ? CADDR_MOD : CADDR_INC;
      end
      OP_BRNZ: begin
        instr_class = CLS_CTRL;
        caddr_cmd   = cond_z ? CADDR_INC : CADDR_MOD;
      end
      OP_HALT: begin
        instr_class = CLS_HALT;
        caddr_cmd   = CADDR_NOP;
      end
      default: begin
        instr_class = CLS_EXEC;
        caddr_cmd   = CADDR_INC;
      end
    endcase
  end

endmodule

// File: rtl/caddr_seq.sv
// Instruction sequencer: fetches a word, decodes it, hands EXEC-class words
// to the execute unit and issues one caddr command per completed instruction.
module caddr_seq
  import bxu_seq_pkg::*;
#(
  parameter int CODE_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     step_mode,
  input  logic                     step,
  input  logic                     cond_z,
  input  logic [ADDR_BITWIDTH-1:0] code_addr,
  caddr_seq_if.master              bus,
  output logic [CODE_BITWIDTH-1:0] code,
  output logic [1:0]               flag_op_caddr,
  output logic                     busy,
  output logic                     halted
);

  logic [2:0]               state_q, state_d;
  logic [CODE_BITWIDTH-1:0] code_q, code_d;
  logic [1:0]               flag_op_q, flag_op_d;
  logic                     ex_valid_q, ex_valid_d;

  instr_class_e dec_class;
  logic [1:0]   dec_cmd;

  seq_op_dec u_dec (
    .opcode      (code_q[3:0]),
    .cond_z      (cond_z),
    .instr_class (dec_class),
    .caddr_cmd   (dec_cmd)
  );

  logic start_req;
  logic continue_run;
  assign start_req    = (!step_mode && run) || (step_mode && step);
  assign continue_run = run && !step_mode;

  // flag_op_d defaults to NOP so the command register is live only in UPDATE
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    flag_op_d  = CADDR_NOP;
    ex_valid_d = ex_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.code_ack) begin
          code_d  = bus.code_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec_class)
          CLS_CTRL: begin
            flag_op_d = dec_cmd;
            state_d   = ST_UPDATE;
          end
          CLS_HALT: state_d = ST_HALTED;
          default: begin
            ex_valid_d = 1'b1;
            state_d    = ST_EXEC;
          end
        endcase
      end
      ST_EXEC: begin
        if (ex_valid_q && bus.ex_ready) begin
          ex_valid_d = 1'b0;
          flag_op_d  = CADDR_INC;
          state_d    = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d = continue_run ? ST_FETCH : ST_IDLE;
      end
      ST_HALTED: begin
        if (!run) state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        ex_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      flag_op_q  <= CADDR_NOP;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      flag_op_q  <= flag_op_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign bus.code_req   = (state_q == ST_FETCH);
  assign bus.fetch_addr = code_addr;
  assign bus.ex_valid   = ex_valid_q;
  assign code           = code_q;
  assign flag_op_caddr  = flag_op_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_caddr_seq.sv
// Self-checking bench for caddr_seq: models code memory, execute unit and the
// code-address register, and scoreboards the command issued per instruction.
module tb_caddr_seq;
  import bxu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run, step_mode, step, cond_z;
  logic [15:0] code_addr;
  logic [15:0] code;
  logic [1:0]  flag_op_caddr;
  logic        busy, halted;

  always #5 clk = ~clk;

  caddr_seq_if bus ();

  caddr_seq dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .step_mode     (step_mode),
    .step          (step),
    .cond_z        (cond_z),
    .code_addr     (code_addr),
    .bus           (bus),
    .code          (code),
    .flag_op_caddr (flag_op_caddr),
    .busy          (busy),
    .halted        (halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, act);
    end
  endtask

  // code memory contents, unwritten addresses read as NOP
  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] rel_target(input logic [15:0] pc, input logic [15:0] w);
    logic [15:0] mag;
    mag = {5'b0, w[14:4]};
    return w[15] ? pc - mag : pc + mag;
  endfunction

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] next_addr;
  } exp_t;
  exp_t sb_q[$];

  logic ack_en, ack_force;
  int   ex_stall;
  logic load_en;
  logic [15:0] load_val;

  // memory and execute-unit responders; the expected outcome of each fetched
  // word is pushed the moment the word is handed over
  int stall_left = 0;
  always @(negedge clk) begin
    logic [15:0] w;
    logic [15:0] pc;
    exp_t e;
    pc = bus.fetch_addr;
    w  = mem_rd(pc);
    bus.code_ack   = ack_en & (bus.code_req | ack_force);
    bus.code_rdata = w;
    if (bus.code_req && ack_en && !rst) begin
      e.cmd = CADDR_INC;
      e.next_addr = pc + 16'd1;
      case (w[3:0])
        OP_JMPR: begin e.cmd = CADDR_MOD; e.next_addr = rel_target(pc, w); end
        OP_JMPA: begin e.cmd = CADDR_SET; e.next_addr = {4'h0, w[15:4]}; end
        OP_BRZ:  if (cond_z)  begin e.cmd = CADDR_MOD; e.next_addr = rel_target(pc, w); end
        OP_BRNZ: if (!cond_z) begin e.cmd = CADDR_MOD; e.next_addr = rel_target(pc, w); end
        default: ;
      endcase
      if (w[3:0] != OP_HALT) sb_q.push_back(e);
    end
    if (bus.ex_valid) begin
      if (stall_left > 0) begin
        bus.ex_ready = 1'b0;
        stall_left--;
      end else begin
        bus.ex_ready = 1'b1;
      end
    end else begin
      bus.ex_ready = 1'b0;
      stall_left = ex_stall;
    end
  end

  // code-address unit model driven by the DUT command and instruction register
  always @(posedge clk) begin
    if (load_en) code_addr <= load_val;
    else begin
      case (flag_op_caddr)
        CADDR_INC: code_addr <= code_addr + 16'd1;
        CADDR_MOD: code_addr <= rel_target(code_addr, code);
        CADDR_SET: code_addr <= {4'h0, code[15:4]};
        default:   code_addr <= code_addr;
      endcase
    end
  end

  // monitor: pops the scoreboard on every command pulse
  int pulse_cnt = 0;
  int ex_cnt = 0;
  int flag_in_ex = 0;
  always @(negedge clk) begin
    static logic addr_pend = 1'b0;
    static logic [15:0] exp_addr = 16'h0;
    exp_t e;
    if (addr_pend) begin
      check_eq("next_addr", code_addr, exp_addr);
      addr_pend = 1'b0;
    end
    if (!rst && flag_op_caddr != CADDR_NOP) begin
      pulse_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_cmd", flag_op_caddr, CADDR_NOP);
      end else begin
        e = sb_q.pop_front();
        check_eq("cmd", flag_op_caddr, e.cmd);
        exp_addr  = e.next_addr;
        addr_pend = 1'b1;
      end
    end
    if (bus.code_req) check_eq("fetch_addr", bus.fetch_addr, code_addr);
    if (bus.ex_valid) begin
      ex_cnt++;
      if (flag_op_caddr != CADDR_NOP) flag_in_ex++;
    end
  end

  task automatic load_addr(input logic [15:0] a);
    load_val = a;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic step_one(input string tag);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, e0, f0;
    rst = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0; cond_z = 1'b0;
    ack_en = 1'b1; ack_force = 1'b0; ex_stall = 0;
    load_en = 1'b1; load_val = 16'h0000;
    bus.code_ack = 1'b0; bus.code_rdata = 16'h0; bus.ex_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_code_req", bus.code_req, 1'b0);
    check_eq("rst_code", code, 16'h0000);
    check_eq("rst_flag", flag_op_caddr, CADDR_NOP);
    check_eq("rst_ex_valid", bus.ex_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_halted", halted, 1'b0);

    // continuous NOPs: one INC every 3 cycles
    load_en = 1'b0; rst = 1'b0; run = 1'b1;
    p0 = pulse_cnt;
    @(negedge clk);
    check_eq("t1_req_cycle1", bus.code_req, 1'b1);
    repeat (8) @(negedge clk);
    run = 1'b0;
    wait_idle("t1_idle");
    #1;
    check_eq("t1_pulses", pulse_cnt - p0, 3);
    check_eq("t1_addr", code_addr, 16'd3);

    // relative jumps forward and backward
    @(negedge clk);
    step_mode = 1'b1;
    mem[16'd5] = 16'h0101;
    load_addr(16'd5);
    step_one("t2_fwd_idle");
    check_eq("t2_fwd_addr", code_addr, 16'd21);
    mem[16'd5] = 16'h8101;
    load_addr(16'd5);
    step_one("t2_back_idle");
    check_eq("t2_back_addr", code_addr, 16'hFFF5);

    // conditional branches and absolute jump
    mem[16'h40] = 16'h0033; cond_z = 1'b0;
    load_addr(16'h40);
    step_one("t3_brz_nt_idle");
    check_eq("t3_brz_nt_addr", code_addr, 16'h41);
    cond_z = 1'b1;
    load_addr(16'h40);
    step_one("t3_brz_t_idle");
    check_eq("t3_brz_t_addr", code_addr, 16'h43);
    mem[16'h40] = 16'h0034;
    load_addr(16'h40);
    step_one("t3_brnz_nt_idle");
    check_eq("t3_brnz_nt_addr", code_addr, 16'h41);
    mem[16'h40] = 16'h1232;
    load_addr(16'h40);
    step_one("t3_jmpa_idle");
    check_eq("t3_jmpa_addr", code_addr, 16'h123);
    cond_z = 1'b0;

    // EXEC with 5 stall cycles
    mem[16'h50] = 16'h0007; ex_stall = 5;
    load_addr(16'h50);
    #1;
    p0 = pulse_cnt; e0 = ex_cnt; f0 = flag_in_ex;
    @(negedge clk);
    step_one("t4_idle");
    #1;
    check_eq("t4_ex_valid_cycles", ex_cnt - e0, 6);
    check_eq("t4_flag_during_ex", flag_in_ex - f0, 0);
    check_eq("t4_pulses", pulse_cnt - p0, 1);
    check_eq("t4_addr", code_addr, 16'h51);
    ex_stall = 0;

    // HALT in run mode, then release
    step_mode = 1'b0;
    mem[16'h60] = 16'h000F;
    load_addr(16'h60);
    #1;
    p0 = pulse_cnt;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    check_eq("t5_halted", halted, 1'b1);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_code", code, 16'h000F);
    repeat (3) @(negedge clk);
    check_eq("t5_still_halted", halted, 1'b1);
    check_eq("t5_addr", code_addr, 16'h60);
    run = 1'b0;
    @(negedge clk);
    check_eq("t5_released", halted, 1'b0);
    check_eq("t5_idle_busy", busy, 1'b0);
    #1;
    check_eq("t5_pulses", pulse_cnt - p0, 0);
    check_eq("t5_addr_after", code_addr, 16'h60);

    // reset during a stalled fetch, then a stray ack
    @(negedge clk);
    ack_en = 1'b0; run = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_req_stalled", bus.code_req, 1'b1);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_code_req", bus.code_req, 1'b0);
    check_eq("t6_rst_code", code, 16'h0000);
    check_eq("t6_rst_flag", flag_op_caddr, CADDR_NOP);
    check_eq("t6_rst_ex_valid", bus.ex_valid, 1'b0);
    check_eq("t6_rst_busy", busy, 1'b0);
    check_eq("t6_rst_halted", halted, 1'b0);
    rst = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    check_eq("t6_stray_ack_busy", busy, 1'b0);
    check_eq("t6_stray_ack_code", code, 16'h0000);

    // step mode: three instructions, extra step during FETCH ignored
    step_mode = 1'b1;
    load_addr(16'h70);
    #1;
    p0 = pulse_cnt;
    ack_en = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    ack_en = 1'b1;
    wait_idle("t7_s1_idle");
    check_eq("t7_s1_addr", code_addr, 16'h71);
    step_one("t7_s2_idle");
    step_one("t7_s3_idle");
    repeat (2) @(negedge clk);
    check_eq("t7_addr", code_addr, 16'h73);
    check_eq("t7_pulses", pulse_cnt - p0, 3);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/caddr_seq.md
# caddr_seq

Instruction sequencer for the code-address unit. Fetches one 16-bit instruction word per step from code memory, decodes its class, and drives the 2-bit `flag_op_caddr` command (NOP/INC/MOD/SET). It also holds the instruction register whose bits the code-address unit reads, and hands non-control instructions to the execute unit over a valid/ready handshake. It sits between code memory, the execute unit and the code-address register.

## Interface
- `CODE_BITWIDTH`, 16, instruction word width; only 16 is supported.
- `ADDR_BITWIDTH`, 16, code address width.
- `CADDR_NOP` / `CADDR_INC` / `CADDR_MOD` / `CADDR_SET`, 2'h0 / 2'h1 / 2'h2 / 2'h3, command encodings.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; enables continuous execution.
- `step_mode`  in  1  when 1, execute one instruction per `step` pulse.
- `step`  in  1  single-cycle pulse; starts one instruction in step mode.
- `cond_z`  in  1  zero flag from the execute unit; sampled in DECODE.
- `code_addr`  in  ADDR_BITWIDTH  current address from the code-address unit.
- `code_req`  out  1  fetch request to code memory.
- `fetch_addr`  out  ADDR_BITWIDTH  equals `code_addr`, passed through.
- `code_ack`  in  1  fetch complete; `code_rdata` is valid in the same cycle.
- `code_rdata`  in  16  fetched word.
- `code`  out  16  instruction register.
- `flag_op_caddr`  out  2  command to the code-address unit.
- `ex_valid`  out  1  instruction offered to the execute unit.
- `ex_ready`  in  1  execute unit accepts and completes the instruction.
- `busy`  out  1  high in any state other than IDLE or HALTED.
- `halted`  out  1  high in HALTED.

## Operation
- Opcode is `code[3:0]`:
  - 0x0 NOP
  - 0x1 JMPR: relative jump. Sign is `code[15]`, magnitude is `code[14:4]`.
  - 0x2 JMPA: absolute jump to `code[15:4]`.
  - 0x3 BRZ: JMPR if `cond_z`=1.
  - 0x4 BRNZ: JMPR if `cond_z`=0.
  - 0xF HALT.
  - 0x5–0xE are EXEC instructions.
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALTED.
- IDLE
  - Go to FETCH when (`step_mode`=0 and `run`=1) or (`step_mode`=1 and `step`=1).
  - `step` is ignored while not in IDLE.
- FETCH
  - `code_req`=1 (Moore output).
  - On `code_ack`: `code` <= `code_rdata`, go to DECODE.
  - Wait indefinitely otherwise.
- DECODE (one cycle)
  - JMPR, and BRZ/BRNZ taken: `flag_op_caddr` <= MOD.
  - JMPA: `flag_op_caddr` <= SET.
  - NOP, and BRZ/BRNZ not taken: `flag_op_caddr` <= INC.
  - For all of the above, next state is UPDATE.
  - EXEC class: `ex_valid` <= 1, go to EXEC.
  - HALT: go to HALTED; `code_addr` is not advanced.
- EXEC
  - Hold `ex_valid`=1 until `ex_valid & ex_ready`.
  - Then `ex_valid` <= 0, `flag_op_caddr` <= INC, go to UPDATE.
- UPDATE (one cycle)
  - `flag_op_caddr` shows the registered command; it returns to NOP on exit.
  - Next state is FETCH if `run`=1 and `step_mode`=0, otherwise IDLE.
- HALTED
  - `halted`=1.
  - Go to IDLE when `run`=0. Leaving HALTED does not advance the address.
- `run` falling mid-instruction: the current instruction completes through UPDATE, then the block goes to IDLE. No request is abandoned.
- `flag_op_caddr` is non-NOP in exactly one cycle per completed instruction, except HALT (zero cycles).
- `code` holds its value from DECODE until the next `code_ack`.

## Timing
- Reset values:
  - state = IDLE
  - `code_req` = 0
  - `code` = 16'h0000
  - `flag_op_caddr` = NOP
  - `ex_valid` = 0
  - `busy` = 0
  - `halted` = 0
- `rst` overrides everything, including mid-FETCH and mid-EXEC. An outstanding `code_ack` arriving after reset is ignored.
- Control instruction with zero-wait memory: 4 cycles per instruction (IDLE→FETCH→DECODE→UPDATE→FETCH…), i.e. 3 cycles per instruction in continuous run.
- EXEC instruction with immediate `ex_ready`: 4 cycles per instruction in continuous run.
- `code_addr` updates on the clock edge that ends UPDATE. FETCH therefore always uses the new address.
- `cond_z` is sampled only in the DECODE cycle.

## Structure
- Shared package `bxu_seq_pkg` holds:
  - state encoding (3-bit);
  - opcode constants (OP_NOP, OP_JMPR, OP_JMPA, OP_BRZ, OP_BRNZ, OP_HALT);
  - `CADDR_*` encodings.
- One sub-module is natural: `seq_op_dec`, a combinational decoder from `code[3:0]` and `cond_z` to class (CTRL/EXEC/HALT) plus the caddr command.

## Test plan
- Reset then `run`=1, memory returns 16'h0000 with immediate ack → `code_req` high in cycle 1; `flag_op_caddr`=INC exactly one cycle in every 3; `code_addr` 0→1→2.
- Fetch 16'h0101 (JMPR +16) at address 5 → MOD pulse; next FETCH at address 21. Fetch 16'h8101 → next FETCH at address 0xFFF5 (5−16, wrapped).
- BRZ 16'h0033 with `cond_z`=0 → INC; with `cond_z`=1 → MOD, address +3.
- EXEC opcode 0x7 with `ex_ready` low for 5 cycles → `ex_valid` high for 6 cycles, `flag_op_caddr` NOP throughout, then a single INC.
- HALT 16'h000F → `halted`=1, no command pulse, address unchanged; drop `run` → IDLE; `rst` mid-FETCH → all outputs at reset values the next cycle.
- `step_mode`=1 with three `step` pulses → exactly three instructions, back to IDLE after each; a `step` during FETCH is ignored.
